// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM encoding,
// default operand width and derived field widths.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int MAG_W     = 2 * WIDTH_DEF - 1;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Counter width for an arbitrary operand width; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/abs_val.sv
// Two's-complement to sign/magnitude split. The most negative input maps to
// 2^(WIDTH-1), which still fits the unsigned WIDTH-bit magnitude.
module abs_val #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  assign neg_o = val_i[WIDTH-1];
  assign mag_o = neg_o ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/seq_signed_mult.sv
// Sequential shift-add signed multiplier producing sign + unsigned magnitude
// WIDTH+1 cycles after the accepting edge; one product per WIDTH+3 cycles.
module seq_signed_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               sign,
  output logic [2*WIDTH-2:0] mag
);

  localparam int MW = 2 * WIDTH - 1;
  localparam int AW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             psign_q, psign_d;
  logic             busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic [MW-1:0]    mag_q, mag_d;

  logic [WIDTH-1:0] a_abs_s, b_abs_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH:0]   sum_s;

  abs_val #(.WIDTH(WIDTH)) u_abs_a (.val_i(a_q), .mag_o(a_abs_s), .neg_o(a_neg_s));
  abs_val #(.WIDTH(WIDTH)) u_abs_b (.val_i(b_q), .mag_o(b_abs_s), .neg_o(b_neg_s));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    psign_d  = psign_q;
    done_d   = 1'b0;
    sign_d   = sign_q;
    mag_d    = mag_q;
    sum_s    = {1'b0, acc_q[AW-1:WIDTH]}
             + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        mcand_d  = a_abs_s;
        mplier_d = b_abs_s;
        psign_d  = a_neg_s ^ b_neg_s;
        acc_d    = {AW{1'b0}};
        cnt_d    = {CW{1'b0}};
        state_d  = RUN;
      end
      RUN: begin
        // Carry out of the upper-half add becomes the new MSB after the shift.
        acc_d    = {sum_s, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          mag_d   = acc_d[MW-1:0];
          sign_d  = psign_q & (|acc_d);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      psign_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= {MW{1'b0}};
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      psign_q  <= psign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sign = sign_q;
  assign mag  = mag_q;

endmodule

// File: tb/tb_seq_signed_mult.sv
// Self-checking bench for seq_signed_mult: timing-level reference model,
// per-cycle output comparison, directed corner products and random sweeps.
module tb_seq_signed_mult;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done, sign;
  logic [14:0] mag;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  seq_signed_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sign(sign), .mag(mag)
  );

  function automatic int ref_prod(input logic [7:0] x, input logic [7:0] y);
    return int'($signed(x)) * int'($signed(y));
  endfunction

  function automatic logic [14:0] ref_mag(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = ref_prod(x, y);
    return 15'((p < 0) ? -p : p);
  endfunction

  function automatic int to_bcd(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model: phase counts edges since acceptance (-1 = idle).
  int          m_phase = -1;
  int          cyc = 0;
  logic [7:0]  ea = 8'd0, eb = 8'd0;
  logic [14:0] m_mag = 15'd0;
  logic        m_sign = 1'b0;
  logic        m_busy, m_done;
  int          acc_log[$];

  assign m_busy = (m_phase >= 0) && (m_phase <= W + 1);
  assign m_done = (m_phase == W + 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= -1;
      m_mag   <= 15'd0;
      m_sign  <= 1'b0;
      cyc     <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_phase < 0) begin
        if (start) begin
          m_phase <= 0;
          ea      <= a;
          eb      <= b;
          acc_log.push_back(cyc);
        end
      end else begin
        if (m_phase == W) begin
          m_mag  <= ref_mag(ea, eb);
          m_sign <= (ref_prod(ea, eb) < 0);
        end
        m_phase <= (m_phase == W + 1) ? -1 : m_phase + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2,
                        input int em, input logic es, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb2;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    chk({nm, "_busy_at_E"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, 9);
    chk({nm, "_mag"}, mag, em);
    chk({nm, "_sign"}, sign, es);
    @(negedge clk);
    chk({nm, "_done_fall"}, done, 0);
    chk({nm, "_busy_fall"}, busy, 0);
  endtask

  task automatic hold_start(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      start = 1'b1; a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    int n0, d0, na;
    rst_n = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mag", mag, 0);
    chk("rst_sign", sign, 0);
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_mag", mag, m_mag);
        chk("cyc_sign", sign, m_sign);
        if (done) done_cnt++;
      end
    join_none

    run_op(8'd7,   8'hFD, 21,    1'b1, "p7xm3");
    run_op(8'h80,  8'h80, 16384, 1'b0, "m128xm128");
    chk("bcd_16384", to_bcd(int'(mag)), 32'h16384);
    run_op(8'h80,  8'h7F, 16256, 1'b1, "m128x127");
    run_op(8'd0,   8'hFB, 0,     1'b0, "zeroxm5");
    run_op(8'hFF,  8'hFF, 1,     1'b0, "m1xm1");
    run_op(8'h7F,  8'h7F, 16129, 1'b0, "127x127");

    n0 = acc_log.size();
    d0 = done_cnt;
    hold_start(33);
    na = acc_log.size() - n0;
    chk("b2b_accepts", na, 3);
    if (na >= 2) chk("b2b_gap", acc_log[n0 + 1] - acc_log[n0], 11);
    else chk("b2b_gap", 0, 11);
    chk("b2b_done_pulses", done_cnt - d0, na);

    run_op(8'h81, 8'd3, 381, 1'b1, "pre_reset");
    @(negedge clk);
    start = 1'b1; a = 8'h90; b = 8'h21;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mag", mag, 0);
    chk("mid_rst_sign", sign, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd5, 8'd5, 25, 1'b0, "after_rst");

    hold_start(22000);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
